// File: rtl/fetch_stage.sv
// fetch_stage: pipeline front end. Owns the fetch PC, issues addresses to a
// synchronous (1-cycle latency) instruction memory and loads the IF/ID
// register (inst_new / pc_count_new / inst_valid) consumed by decoInst.
// Optional build macro FETCH_PERF_EN adds saturating fetch/squash counters.
module fetch_stage #(
    parameter int unsigned       PC_W     = 16,
    parameter int unsigned       INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_rden,
    input  logic [INST_W-1:0] imem_q,
    output logic [PC_W-1:0]   pc_count,
    output logic [INST_W-1:0] inst_new,
    output logic [PC_W-1:0]   pc_count_new,
    output logic              inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);

    logic              hold;

    logic [PC_W-1:0]   pc_q,       pc_d;
    logic              req_valid_q, req_valid_d;
    logic [PC_W-1:0]   req_pc_q,   req_pc_d;
    logic [INST_W-1:0] inst_q,     inst_d;
    logic [PC_W-1:0]   pcn_q,      pcn_d;
    logic              valid_q,    valid_d;

    // en=0 is treated exactly like a stall
    assign hold = stall | ~en;

    // Memory is read only when the front end advances, so q stays aligned
    // with req_pc across a stall.
    assign imem_rden    = ~hold & rst;
    assign imem_addr    = pc_q;
    assign pc_count     = pc_q;
    assign inst_new     = inst_q;
    assign pc_count_new = pcn_q;
    assign inst_valid   = valid_q;

    // Next-state for PC, in-flight request tracker and IF/ID register
    always_comb begin
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        inst_d      = inst_q;
        pcn_d       = pcn_q;
        valid_d     = valid_q;

        // PC: redirect beats hold beats sequential increment (wraps naturally)
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (!hold) begin
            pc_d = pc_q + PC_W'(1);
        end

        // Tracker records the address presented to memory this cycle
        if (!hold) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
        end

        // IF/ID: a redirect squashes both the slot and the in-flight word
        if (branch_taken) begin
            inst_d      = NOP_INST;
            valid_d     = 1'b0;
            req_valid_d = 1'b0;
        end else if (!hold) begin
            inst_d  = req_valid_q ? imem_q : NOP_INST;
            pcn_d   = req_pc_q;
            valid_d = req_valid_q;
        end
    end

    // Fetch state registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            inst_q      <= NOP_INST;
            pcn_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            inst_q      <= inst_d;
            pcn_q       <= pcn_d;
            valid_q     <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q,  perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic        fetch_evt;
    logic        squash_evt;

    // A fetch is an IF/ID load carrying a valid instruction; a squash is a
    // redirect that discards at least one live word.
    assign fetch_evt  = ~branch_taken & ~hold & req_valid_q;
    assign squash_evt = branch_taken & (req_valid_q | valid_q);

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;

    // Saturating event counters
    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = perf_squashed_q;
        if (fetch_evt && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (squash_evt && (perf_squashed_q != '1)) begin
            perf_squashed_d = perf_squashed_q + 32'd1;
        end
    end

    // Counter registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// wrap / async-reset / counter sequences, then randomized traffic against a
// transaction-level reference model. Two instances: RESET_PC=0 and 0xFFFE.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stall;
    logic        br;
    logic [15:0] tgt;

    logic [15:0] addr0, pc0, pcn0, addr1, pc1, pcn1;
    logic        rden0, v0, rden1, v1;
    logic [31:0] q0, inst0, q1, inst1;
`ifdef FETCH_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(16), .INST_W(32), .RESET_PC(16'h0000), .NOP_INST(32'h0)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr0), .imem_rden(rden0), .imem_q(q0),
        .pc_count(pc0), .inst_new(inst0), .pc_count_new(pcn0), .inst_valid(v0)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf0), .perf_squashed(ps0)
`endif
    );

    fetch_stage #(.PC_W(16), .INST_W(32), .RESET_PC(16'hFFFE), .NOP_INST(32'h0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr1), .imem_rden(rden1), .imem_q(q1),
        .pc_count(pc1), .inst_new(inst1), .pc_count_new(pcn1), .inst_valid(v1)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf1), .perf_squashed(ps1)
`endif
    );

    // Instruction memory contents: mem[a] = a + 0x100
    function automatic logic [31:0] memw(input logic [15:0] a);
        return {16'h0000, a} + 32'h100;
    endfunction

    // Synchronous memories: 1-cycle read, q held while rden is low
    always @(posedge clk) if (rden0) q0 <= memw(addr0);
    always @(posedge clk) if (rden1) q1 <= memw(addr1);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks which addresses sit in flight and in IF/ID.
    // The delivered word is derived from the memory contents, not from q.
    typedef struct {
        logic [15:0] pc;
        bit          rq_v;
        logic [15:0] rq_pc;
        bit          v;
        logic [15:0] pcn;
        logic [31:0] pf;
        logic [31:0] ps;
    } mstate_t;

    function automatic mstate_t mreset(input logic [15:0] rpc);
        mstate_t m;
        m.pc = rpc; m.rq_v = 0; m.rq_pc = 0; m.v = 0; m.pcn = 0; m.pf = 0; m.ps = 0;
        return m;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input bit h, input bit b,
                                      input logic [15:0] t);
        mstate_t n = m;
        if (b) n.pc = t;
        else if (!h) n.pc = 16'((32'(m.pc) + 1) % 65536);
        if (!h) begin n.rq_v = 1; n.rq_pc = m.pc; end
        if (b) begin
            n.rq_v = 0; n.v = 0;
            if ((m.rq_v || m.v) && m.ps != 32'hFFFF_FFFF) n.ps = m.ps + 1;
        end else if (!h) begin
            n.v = m.rq_v; n.pcn = m.rq_pc;
            if (m.rq_v && m.pf != 32'hFFFF_FFFF) n.pf = m.pf + 1;
        end
        return n;
    endfunction

    task automatic mcheck(input string tag, input mstate_t m, input logic [15:0] pc,
                          input logic [15:0] addr, input bit v, input logic [31:0] inst,
                          input logic [15:0] pcn);
        chk({tag, " pc_count"},     32'(pc),   32'(m.pc));
        chk({tag, " imem_addr"},    32'(addr), 32'(m.pc));
        chk({tag, " inst_valid"},   32'(v),    32'(m.v));
        chk({tag, " inst_new"},     inst,      m.v ? memw(m.pcn) : 32'h0);
        chk({tag, " pc_count_new"}, 32'(pcn),  32'(m.pcn));
    endtask

    typedef struct {
        bit          en, stall, br;
        logic [15:0] tgt;
        bit          rden;
        logic [15:0] pc;
        bit          v;
        logic [31:0] inst;
        logic [15:0] pcn;
    } vec_t;

    vec_t    tbl[21];
    mstate_t m0, m1;

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // {en, stall, br, tgt, rden, pc after edge, valid, inst, pc tag}
        tbl[0]  = '{1, 0, 0, 16'h00, 1, 16'h01, 0, 32'h000, 16'h00};
        tbl[1]  = '{1, 0, 0, 16'h00, 1, 16'h02, 1, 32'h100, 16'h00};
        tbl[2]  = '{1, 0, 0, 16'h00, 1, 16'h03, 1, 32'h101, 16'h01};
        tbl[3]  = '{1, 0, 0, 16'h00, 1, 16'h04, 1, 32'h102, 16'h02};
        tbl[4]  = '{1, 0, 0, 16'h00, 1, 16'h05, 1, 32'h103, 16'h03};
        tbl[5]  = '{1, 1, 0, 16'h00, 0, 16'h05, 1, 32'h103, 16'h03};
        tbl[6]  = '{1, 1, 0, 16'h00, 0, 16'h05, 1, 32'h103, 16'h03};
        tbl[7]  = '{1, 1, 0, 16'h00, 0, 16'h05, 1, 32'h103, 16'h03};
        tbl[8]  = '{1, 0, 0, 16'h00, 1, 16'h06, 1, 32'h104, 16'h04};
        tbl[9]  = '{1, 0, 0, 16'h00, 1, 16'h07, 1, 32'h105, 16'h05};
        tbl[10] = '{1, 0, 1, 16'h40, 1, 16'h40, 0, 32'h000, 16'h05};
        tbl[11] = '{1, 0, 0, 16'h00, 1, 16'h41, 0, 32'h000, 16'h07};
        tbl[12] = '{1, 0, 0, 16'h00, 1, 16'h42, 1, 32'h140, 16'h40};
        tbl[13] = '{1, 0, 0, 16'h00, 1, 16'h43, 1, 32'h141, 16'h41};
        tbl[14] = '{1, 1, 1, 16'h20, 0, 16'h20, 0, 32'h000, 16'h41};
        tbl[15] = '{1, 0, 0, 16'h00, 1, 16'h21, 0, 32'h000, 16'h42};
        tbl[16] = '{1, 0, 0, 16'h00, 1, 16'h22, 1, 32'h120, 16'h20};
        tbl[17] = '{0, 0, 0, 16'h00, 0, 16'h22, 1, 32'h120, 16'h20};
        tbl[18] = '{0, 1, 0, 16'h00, 0, 16'h22, 1, 32'h120, 16'h20};
        tbl[19] = '{1, 0, 0, 16'h00, 1, 16'h23, 1, 32'h121, 16'h21};
        tbl[20] = '{1, 0, 0, 16'h00, 1, 16'h24, 1, 32'h122, 16'h22};

        rst = 1'b1; en = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
        #3 rst = 1'b0;
        #1;
        chk("reset pc_count",     32'(pc0),   32'h0);
        chk("reset inst_valid",   32'(v0),    32'h0);
        chk("reset inst_new",     inst0,      32'h0);
        chk("reset pc_count_new", 32'(pcn0),  32'h0);
        chk("reset imem_rden",    32'(rden0), 32'h0);
        chk("reset wrap pc",      32'(pc1),   32'hFFFE);
        release_reset();

        // Directed table: free run, stall, redirect, redirect+stall, en=0
        for (int i = 0; i < 21; i++) begin
            en = tbl[i].en; stall = tbl[i].stall; br = tbl[i].br; tgt = tbl[i].tgt;
            #1 chk($sformatf("row%0d imem_rden", i), 32'(rden0), 32'(tbl[i].rden));
            @(negedge clk);
            chk($sformatf("row%0d pc_count", i),     32'(pc0),   32'(tbl[i].pc));
            chk($sformatf("row%0d imem_addr", i),    32'(addr0), 32'(tbl[i].pc));
            chk($sformatf("row%0d inst_valid", i),   32'(v0),    32'(tbl[i].v));
            chk($sformatf("row%0d inst_new", i),     inst0,      tbl[i].inst);
            chk($sformatf("row%0d pc_count_new", i), 32'(pcn0),  32'(tbl[i].pcn));
        end
        en = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;

        // PC wrap on the RESET_PC=0xFFFE instance
        @(negedge clk); rst = 1'b0;
        release_reset();
        chk("wrap start pc", 32'(pc1), 32'hFFFE);
        @(negedge clk);
        chk("wrap c1 pc", 32'(pc1), 32'hFFFF);
        chk("wrap c1 valid", 32'(v1), 32'h0);
        @(negedge clk);
        chk("wrap c2 pc", 32'(pc1), 32'h0000);
        chk("wrap c2 inst", inst1, 32'h100FE);
        chk("wrap c2 tag", 32'(pcn1), 32'hFFFE);
        @(negedge clk);
        chk("wrap c3 pc", 32'(pc1), 32'h0001);
        chk("wrap c3 inst", inst1, 32'h100FF);
        chk("wrap c3 tag", 32'(pcn1), 32'hFFFF);
        @(negedge clk);
        chk("wrap c4 inst", inst1, 32'h100);
        chk("wrap c4 tag", 32'(pcn1), 32'h0000);

        // Asynchronous reset between edges, mid-stream
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("async pc_count",     32'(pc0),   32'h0);
        chk("async inst_valid",   32'(v0),    32'h0);
        chk("async inst_new",     inst0,      32'h0);
        chk("async pc_count_new", 32'(pcn0),  32'h0);
        chk("async imem_rden",    32'(rden0), 32'h0);
        chk("async wrap pc",      32'(pc1),   32'hFFFE);
        release_reset();
        #1 chk("post-reset imem_rden", 32'(rden0), 32'h1);
        chk("post-reset imem_addr", 32'(addr0), 32'h0);

`ifdef FETCH_PERF_EN
        chk("perf fetched after reset",  pf0, 32'h0);
        chk("perf squashed after reset", ps0, 32'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        br = 1'b1; tgt = 16'h80;
        @(negedge clk);
        br = 1'b0; tgt = '0;
        chk("perf fetched after run",    pf0, 32'h2);
        chk("perf squashed after branch", ps0, 32'h1);
`endif

        // Randomized traffic against the reference model
        @(negedge clk); rst = 1'b0;
        release_reset();
        m0 = mreset(16'h0000);
        m1 = mreset(16'hFFFE);
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            br    = ($urandom_range(0, 7) == 0);
            tgt   = 16'($urandom);
            #1;
            chk("rnd imem_rden", 32'(rden0), 32'(!(stall || !en)));
            chk("rnd wrap imem_rden", 32'(rden1), 32'(!(stall || !en)));
            @(posedge clk);
            m0 = mstep(m0, stall || !en, br, tgt);
            m1 = mstep(m1, stall || !en, br, tgt);
            @(negedge clk);
            mcheck("rnd", m0, pc0, addr0, v0, inst0, pcn0);
            mcheck("rnd wrap", m1, pc1, addr1, v1, inst1, pcn1);
`ifdef FETCH_PERF_EN
            chk("rnd perf_fetched",  pf0, m0.pf);
            chk("rnd perf_squashed", ps0, m0.ps);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
